// File: rtl/mult_fp_arb_pkg.sv
// Shared types and the round-robin pick helper for the FP32 multiplier arbiter.
// Pure combinational helpers: no latency, no backpressure of their own.
package mult_fp_arb_pkg;
    localparam int FP32_W   = 32;
    localparam int MAX_REQ  = 8;
    localparam int MAX_ID_W = 3;

    typedef struct packed {
        logic                vld;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } pick_t;

    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]  vld,
                                      input logic [MAX_ID_W-1:0] ptr,
                                      input int                  n);
        pick_t res;
        int    cand;
        res = '0;
        // Walk from the farthest candidate back to ptr+1 so the nearest one wins.
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= n) begin
                cand = (int'(ptr) + k) % n;
                if (vld[cand[MAX_ID_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = cand[MAX_ID_W-1:0];
                end
            end
        end
        return res;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: registered pointer, combinational grant searched from pointer+1.
// Grant is same-cycle; the pointer only moves when the owner reports an actual issue.
module rr_arbiter
    import mult_fp_arb_pkg::*;
#(
    parameter int N = 4
)(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [N-1:0]        i_req,
    input  logic                i_update,
    output logic                o_gnt_vld,
    output logic [MAX_ID_W-1:0] o_gnt_idx
);
    logic [MAX_ID_W-1:0] r_ptr;
    logic [MAX_REQ-1:0]  w_req_ext;
    pick_t               w_pick;

    always_comb begin
        w_req_ext        = '0;
        w_req_ext[N-1:0] = i_req;
    end

    assign w_pick    = rr_pick(w_req_ext, r_ptr, N);
    assign o_gnt_vld = w_pick.found;
    assign o_gnt_idx = w_pick.idx;

    // Reset to the last index so requester 0 wins the first arbitration.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= MAX_ID_W'(N - 1);
        end else if (i_update) begin
            r_ptr <= o_gnt_idx;
        end
    end
endmodule

// File: rtl/mult_fp_arbiter.sv
// Shares one pipelined FP32 multiplier among NUM_REQ requesters with a tagged result port.
// Latency MULT_LAT enabled cycles; a stalled result freezes the tags and the multiplier enables.
module mult_fp_arbiter
    import mult_fp_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MULT_LAT = 4,
    parameter int ID_W     = $clog2(NUM_REQ)
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*FP32_W-1:0] req_a,
    input  logic [NUM_REQ*FP32_W-1:0] req_b,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [FP32_W-1:0]         res_data,
    output logic [ID_W-1:0]           res_id,
    output logic                      busy,
    output logic [FP32_W-1:0]         mult_a,
    output logic [FP32_W-1:0]         mult_b,
    output logic [2:0]                mult_ena,
    output logic                      mult_clr,
    input  logic [FP32_W-1:0]         mult_result
);
    tag_t                r_tag [MULT_LAT];
    logic                w_stall;
    logic                w_issue;
    logic                w_gnt_vld;
    logic [MAX_ID_W-1:0] w_gnt_idx;
    logic                w_busy;
    logic [FP32_W-1:0]   w_mult_a;
    logic [FP32_W-1:0]   w_mult_b;

    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req_valid),
        .i_update  (w_issue),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_idx (w_gnt_idx)
    );

    assign w_stall = res_valid & ~res_ready;
    // Ready is withheld during reset so no pair is accepted into a pipeline being flushed.
    assign w_issue   = w_gnt_vld & ~w_stall & ~rst;
    assign req_ready = w_issue ? (NUM_REQ'(1) << w_gnt_idx) : '0;

    always_comb begin
        w_mult_a = '0;
        w_mult_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == MAX_ID_W'(i)) begin
                w_mult_a = req_a[i*FP32_W +: FP32_W];
                w_mult_b = req_b[i*FP32_W +: FP32_W];
            end
        end
    end

    assign mult_a = w_mult_a;
    assign mult_b = w_mult_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MULT_LAT; k++) begin
                r_tag[k] <= '0;
            end
        end else if (!w_stall) begin
            r_tag[0] <= tag_t'{vld: w_issue, id: w_gnt_idx};
            for (int k = 1; k < MULT_LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int k = 0; k < MULT_LAT; k++) begin
            w_busy = w_busy | r_tag[k].vld;
        end
    end

    assign busy      = w_busy;
    assign res_valid = r_tag[MULT_LAT-1].vld;
    assign res_id    = ID_W'(r_tag[MULT_LAT-1].id);
    assign res_data  = mult_result;
    // Enables stay high while clearing so the multiplier flush is not masked by a stale stall.
    assign mult_ena  = (w_stall && !rst) ? 3'b000 : 3'b111;
    assign mult_clr  = rst;
endmodule

// File: tb/tb_mult_fp_arbiter.sv
// Scoreboard bench: behavioural multiplier, rotating-grant model and product queue.
module tb_mult_fp_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int MULT_LAT = 4;
    localparam int ID_W     = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*32-1:0]   req_a = '0;
    logic [NUM_REQ*32-1:0]   req_b = '0;
    logic                    res_valid;
    logic                    res_ready = 1'b1;
    logic [31:0]             res_data;
    logic [ID_W-1:0]         res_id;
    logic                    busy;
    logic [31:0]             mult_a, mult_b, mult_result;
    logic [2:0]              mult_ena;
    logic                    mult_clr;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     data;
    } exp_t;

    exp_t               exp_q[$];
    logic [NUM_REQ-1:0] fired = '0;
    int                 model_last = NUM_REQ - 1;
    int                 checks = 0;
    int                 errors = 0;
    logic [31:0]        mpipe [MULT_LAT];

    mult_fp_arbiter #(.NUM_REQ(NUM_REQ), .MULT_LAT(MULT_LAT), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
        .busy(busy), .mult_a(mult_a), .mult_b(mult_b), .mult_ena(mult_ena),
        .mult_clr(mult_clr), .mult_result(mult_result)
    );

    always #5 clk = ~clk;

    // Operands carry at most 8 mantissa bits, so the significand product is exact.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [8:0]  e;
        logic [22:0] m;
        p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
        e = {1'b0, a[30:23]} + {1'b0, b[30:23]} - 9'd127;
        if (p[47]) begin
            e = e + 9'd1;
            m = p[46:24];
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0] e;
        logic [7:0] m;
        e = 8'($urandom_range(110, 144));
        m = 8'($urandom_range(0, 255));
        return {1'($urandom_range(0, 1)), e, m, 15'b0};
    endfunction

    function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (mult_clr) begin
            for (int k = 0; k < MULT_LAT; k++) mpipe[k] <= '0;
        end else if (mult_ena == 3'b111) begin
            mpipe[0] <= fp_mul(mult_a, mult_b);
            for (int k = 1; k < MULT_LAT; k++) mpipe[k] <= mpipe[k-1];
        end
    end
    assign mult_result = mpipe[MULT_LAT-1];

    // Monitor: checks control outputs, pops on result handshakes, pushes on issue handshakes.
    always @(negedge clk) begin
        logic               stall;
        int                 g;
        logic [NUM_REQ-1:0] exp_rdy;
        exp_t               e;
        chk("mult_clr", 64'(mult_clr), 64'(rst));
        if (rst) begin
            exp_q.delete();
            model_last = NUM_REQ - 1;
            fired = '0;
        end else begin
            chk("busy", 64'(busy), 64'(exp_q.size() != 0));
            if (res_valid) chk("res_valid_has_expected", 64'(exp_q.size() != 0), 64'd1);
            stall = res_valid & ~res_ready;
            chk("mult_ena", 64'(mult_ena), stall ? 64'd0 : 64'd7);
            g = model_pick(req_valid, model_last);
            exp_rdy = (g >= 0 && !stall) ? (NUM_REQ'(1) << g) : '0;
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            fired = req_valid & req_ready;
            if (res_valid && res_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("res_id", 64'(res_id), 64'(e.id));
                chk("res_data", 64'(res_data), 64'(e.data));
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (fired[i]) begin
                    e.id   = ID_W'(i);
                    e.data = fp_mul(req_a[i*32 +: 32], req_b[i*32 +: 32]);
                    exp_q.push_back(e);
                    model_last = i;
                end
            end
        end
    end

    // Requesters keep valid and operands until accepted; new pairs follow 'want'.
    task automatic drive_step(input logic [NUM_REQ-1:0] want);
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (fired[i] || !req_valid[i]) begin
                req_valid[i]        = want[i];
                req_a[i*32 +: 32]   = rand_op();
                req_b[i*32 +: 32]   = rand_op();
            end
        end
    endtask

    task automatic drain(input string nm);
        logic done;
        done = 1'b0;
        for (int c = 0; c < 500 && !done; c++) begin
            drive_step('0);
            res_ready = 1'b1;
            @(negedge clk);
            done = (req_valid == '0) && !busy && (exp_q.size() == 0);
        end
        chk(nm, 64'(done), 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_mult_ena", 64'(mult_ena), 64'd7);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0]     cap_d;
        logic [ID_W-1:0] cap_id;
        cap_d  = '0;
        cap_id = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_mult_ena", 64'(mult_ena), 64'd7);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_res_valid", 64'(res_valid), 64'd0);

        // Single request on requester 2: 2.0 * 3.0.
        drive_step(4'b0100);
        req_a[2*32 +: 32] = 32'h4000_0000;
        req_b[2*32 +: 32] = 32'h4040_0000;
        @(negedge clk);
        chk("t1_req_ready", 64'(req_ready), 64'b0100);
        for (int c = 1; c <= MULT_LAT; c++) begin
            drive_step('0);
            @(negedge clk);
            chk("t1_res_valid", 64'(res_valid), 64'(c == MULT_LAT));
            if (c == MULT_LAT) begin
                chk("t1_res_data", 64'(res_data), 64'h40C0_0000);
                chk("t1_res_id", 64'(res_id), 64'd2);
                chk("t1_busy", 64'(busy), 64'd1);
            end
        end
        drive_step('0);
        @(negedge clk);
        chk("t1_busy_fall", 64'(busy), 64'd0);
        drain("t1_drain");

        // Full contention after reset: ids rotate 0,1,2,3,...
        do_reset();
        for (int c = 0; c < MULT_LAT + 8; c++) begin
            drive_step(c < 8 ? 4'b1111 : 4'b0000);
            @(negedge clk);
            if (c >= MULT_LAT) begin
                chk("t2_res_valid", 64'(res_valid), 64'd1);
                chk("t2_res_id", 64'(res_id), 64'((c - MULT_LAT) % NUM_REQ));
            end
        end
        drain("t2_drain");

        // Backpressure with a full pipeline.
        for (int c = 0; c < MULT_LAT + 2; c++) begin
            drive_step(4'b1111);
            @(negedge clk);
        end
        for (int s = 0; s < 5; s++) begin
            drive_step(4'b1111);
            res_ready = 1'b0;
            @(negedge clk);
            chk("t3_res_valid", 64'(res_valid), 64'd1);
            chk("t3_mult_ena", 64'(mult_ena), 64'd0);
            chk("t3_req_ready", 64'(req_ready), 64'd0);
            if (s == 0) begin
                cap_d  = res_data;
                cap_id = res_id;
            end else begin
                chk("t3_hold_data", 64'(res_data), 64'(cap_d));
                chk("t3_hold_id", 64'(res_id), 64'(cap_id));
            end
        end
        drain("t3_drain");

        // Bubbles: requester 1 every other cycle, consumer not ready when head is empty.
        for (int c = 0; c < MULT_LAT + 8; c++) begin
            drive_step((c % 2 == 0 && c < 8) ? 4'b0010 : 4'b0000);
            res_ready = (c >= MULT_LAT) && ((c - MULT_LAT) % 2 == 0);
            @(negedge clk);
            if (c < 8 && c % 2 == 0) chk("t4_req_ready", 64'(req_ready), 64'b0010);
            if (c >= MULT_LAT) begin
                chk("t4_res_valid", 64'(res_valid), 64'((c - MULT_LAT) % 2 == 0));
                chk("t4_mult_ena", 64'(mult_ena), 64'd7);
                if ((c - MULT_LAT) % 2 == 0) chk("t4_res_id", 64'(res_id), 64'd1);
            end
        end
        drain("t4_drain");

        // Reset mid-flight: three pairs issued, then a one-cycle reset.
        drive_step(4'b1110);
        @(negedge clk);
        drive_step('0);
        @(negedge clk);
        drive_step('0);
        @(negedge clk);
        drive_step('0);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_mult_clr", 64'(mult_clr), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < MULT_LAT + 3; c++) begin
            drive_step('0);
            @(negedge clk);
            chk("t5_no_res_valid", 64'(res_valid), 64'd0);
            chk("t5_busy", 64'(busy), 64'd0);
        end
        drive_step(4'b1111);
        @(negedge clk);
        chk("t5_first_grant", 64'(req_ready), 64'b0001);
        drain("t5_drain");

        // Randomised valid/ready traffic.
        for (int c = 0; c < 10000; c++) begin
            drive_step(NUM_REQ'($urandom));
            res_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
        end
        drain("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
